muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Sequential, width-parametrised multiply/divide unit for the CPU datapath. It replaces the single-cycle combinational MUL and DIV paths with a shift-add multiplier and a restoring divider. Each operation costs one iteration per half-width bit, which removes the wide combinational divider from the critical path. The CPU microcode starts an operation, stalls on `busy`, and writes back `R` and `flags` on the `done` pulse.

## Interface
- `WIDTH`, default 16: result width; must be even and ≥ 8. `HALF = WIDTH/2`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only when the unit can accept (IDLE or DONE).
- `op`  in  1  0 = MUL, 1 = DIV.
- `A`  in  WIDTH  MUL: only `A[HALF-1:0]` is used. DIV: full dividend.
- `B`  in  HALF  multiplier or divisor.
- `busy`  out  1  high while an accepted operation has not yet completed.
- `done`  out  1  one-cycle pulse; `R` and `flags` are valid from this cycle on.
- `R`  out  WIDTH  MUL: product. DIV: `{remainder, quotient}`.
- `flags`  out  4  bit0 Z, bit1 C, bit2 V, bit3 S (CPU flag order).

## Operation
- State machine: IDLE → CALC → DONE → IDLE.
  - DONE is exactly one cycle.
  - `start` in DONE goes straight to CALC (back-to-back operation).
  - A fast path goes IDLE/DONE → DONE directly.
- On accept, latch `op`, `A` and `B` into internal registers. Input changes after the accept edge have no effect.
- MUL: unsigned `A[HALF-1:0] * B`, computed LSB-first by shift-add over HALF iterations.
  - Flags: Z = (R == 0), C = 0, V = 0, S = R[WIDTH-1].
- DIV: unsigned restoring division, one quotient bit per cycle MSB-first, HALF iterations.
  - Flags: Z = (quotient == 0), C = 0, V = 0, S = quotient[HALF-1].
- DIV fast paths, evaluated at accept; no CALC cycles:
  - B == 0: R = A, flags Z=0, C=0, V=1, S=1.
  - Quotient overflow, i.e. A[WIDTH-1:HALF] ≥ B (quotient does not fit HALF bits): R = A, flags Z=0, C=0, V=1, S=0.
  - B == 0 takes priority over overflow.
- `R` and `flags` update only in the DONE cycle and hold until the next DONE.
- `start` while in CALC is ignored: no queueing, no error.
- `reset` (including mid-CALC) forces IDLE and aborts the operation. It clears `busy`, `done`, `R`, `flags` and all internal registers. No `done` is ever produced for an aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `R`=0, `flags`=0, state IDLE.
- `start` accepted at edge N:
  - Iterative: `busy` is 1 in cycles N+1..N+HALF (CALC). `done`=1 and `busy`=0 in cycle N+HALF+1.
  - Fast path: `done`=1 in cycle N+1; `busy` stays 0.
- `done` is never high for two consecutive cycles unless a new `start` was accepted in the first of them.
- Back-to-back: `start` held high through DONE starts the next operation. The next `busy` rises in the cycle after `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `MULDIV_EARLY_TERM_EN`.
- Defined:
  - MUL leaves CALC as soon as the remaining unshifted multiplier bits are all zero. CALC then lasts max(1, index of highest set bit of B + 1) cycles.
  - MUL with B == 0 takes the 1-cycle fast path (R=0, Z=1).
  - DIV latency is unchanged.
- Undefined: MUL always takes exactly HALF CALC cycles, including B == 0. Latency is fixed and data-independent.

## Test plan
- WIDTH=16, MUL A=0x0012, B=0x34 → `done` at N+9, R=0x03A8, flags=0x0. With the macro defined: `done` at N+7.
- DIV A=0x1234, B=0x56 → `done` at N+9, R=0x1036 (rem 0x10, quot 0x36), flags=0x0.
- DIV A=0x1234, B=0x00 → `done` at N+1, `busy` never high, R=0x1234, flags=0xC.
- DIV A=0x1234, B=0x12 (overflow) → `done` at N+1, R=0x1234, flags=0x4. A second DIV A=0x0012, B=0x13 then gives R=0x1200, flags=0x1 (Z).
- Assert `reset` for 1 cycle at N+4 of a MUL → next cycle `busy`=0, R=0, flags=0, no `done`. A fresh MUL A=0x00FF, B=0xFF then gives R=0xFE01, flags=0x8.
- `start` held high for 40 cycles with alternating MUL/DIV (16-bit, iterative) → exactly one `done` per operation, spaced 9 cycles apart. `start` pulses during CALC are ignored.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential shift-add multiplier / restoring divider.
// Optional MULDIV_EARLY_TERM_EN: MUL exits CALC once remaining multiplier bits are zero.
module muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH/2-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   R,
    output logic [3:0]         flags
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(HALF) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [HALF-1:0]  bq_q, bq_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [3:0]       flags_q, flags_d;

    logic [HALF:0]    div_tmp;
    logic             div_ge;
    logic [HALF-1:0]  div_rem_n;
    logic [HALF-1:0]  div_quo_n;
    logic [WIDTH-1:0] mul_acc_n;
    logic [HALF-1:0]  mul_b_n;
    logic             last_iter;
    logic             mul_last;

    // One iteration of each datapath; the dividend low half doubles as quotient
    always_comb begin
        div_tmp   = {acc_q[WIDTH-1:HALF], acc_q[HALF-1]};
        div_ge    = (div_tmp >= {1'b0, bq_q});
        div_rem_n = div_ge ? HALF'(div_tmp - {1'b0, bq_q})
                           : div_tmp[HALF-1:0];
        div_quo_n = {acc_q[HALF-2:0], div_ge};
        mul_acc_n = acc_q + (bq_q[0] ? mcand_q : '0);
        mul_b_n   = bq_q >> 1;
        last_iter = (cnt_q == CW'(HALF - 1));
`ifdef MULDIV_EARLY_TERM_EN
        mul_last  = last_iter || (mul_b_n == '0);
`else
        mul_last  = last_iter;
`endif
    end

    // Next-state, operand latching, fast paths and result capture
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        bq_d    = bq_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        flags_d = flags_q;
        case (state_q)
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (!op_q) begin
                    acc_d   = mul_acc_n;
                    mcand_d = mcand_q << 1;
                    bq_d    = mul_b_n;
                    if (mul_last) begin
                        state_d = S_DONE;
                        r_d     = mul_acc_n;
                        flags_d = {mul_acc_n[WIDTH-1], 2'b00,
                                   mul_acc_n == '0};
                    end
                end else begin
                    acc_d = {div_rem_n, div_quo_n};
                    if (last_iter) begin
                        state_d = S_DONE;
                        r_d     = {div_rem_n, div_quo_n};
                        flags_d = {div_quo_n[HALF-1], 2'b00,
                                   div_quo_n == '0};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    op_d  = op;
                    bq_d  = B;
                    cnt_d = '0;
                    if (!op) begin
                        acc_d   = '0;
                        mcand_d = {{HALF{1'b0}}, A[HALF-1:0]};
                        state_d = S_CALC;
`ifdef MULDIV_EARLY_TERM_EN
                        if (B == '0) begin
                            state_d = S_DONE;
                            r_d     = '0;
                            flags_d = 4'b0001;
                        end
`endif
                    end else begin
                        acc_d   = A;
                        mcand_d = '0;
                        if (B == '0) begin
                            state_d = S_DONE;
                            r_d     = A;
                            flags_d = 4'b1100;
                        end else if (A[WIDTH-1:HALF] >= B) begin
                            state_d = S_DONE;
                            r_d     = A;
                            flags_d = 4'b0100;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
            end
        endcase
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            bq_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            bq_q    <= bq_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            r_q     <= r_d;
            flags_q <= flags_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign R     = r_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq (WIDTH=16).
// Expected results come from plain-arithmetic reference model.
module tb_muldiv_seq;

    localparam int WIDTH = 16;
    localparam int HALF  = 8;

    typedef struct packed {
        logic [15:0] r;
        logic [3:0]  f;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] A = '0;
    logic [7:0]  B = '0;
    logic        busy;
    logic        done;
    logic [15:0] R;
    logic [3:0]  flags;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   blo = 1;
    int   bhi = 0;
    int   last_done = 0;
    int   last_n = 0;
    bit   mon_en = 1'b0;
    logic [15:0] hold_r = '0;
    logic [3:0]  hold_f = '0;
    exp_t sb[$];

    muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .flags (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     name, cyc, act, exp);
        end
    endtask

    // Reference: product / quotient+remainder straight from arithmetic
    task automatic model(input logic o, input logic [15:0] a,
                         input logic [7:0] b, output logic [15:0] r,
                         output logic [3:0] f, output int lat);
        int p;
        int q;
        int rm;
        if (!o) begin
            p   = int'(a[7:0]) * int'(b);
            r   = 16'(p);
            f   = {r[15], 2'b00, r == 16'd0};
            lat = HALF + 1;
`ifdef MULDIV_EARLY_TERM_EN
            begin
                int hb;
                hb = -1;
                for (int i = 0; i < HALF; i++)
                    if (b[i]) hb = i;
                lat = (hb < 0) ? 1 : hb + 2;
            end
`endif
        end else if (b == 8'd0) begin
            r = a; f = 4'b1100; lat = 1;
        end else if (int'(a[15:8]) >= int'(b)) begin
            r = a; f = 4'b0100; lat = 1;
        end else begin
            q   = int'(a) / int'(b);
            rm  = int'(a) % int'(b);
            r   = {8'(rm), 8'(q)};
            f   = {q[7], 2'b00, q == 0};
            lat = HALF + 1;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive an accepted request and record its expected response
    task automatic issue(input logic o, input logic [15:0] a,
                         input logic [7:0] b);
        exp_t e;
        logic [15:0] r;
        logic [3:0]  f;
        int lat;
        int n;
        model(o, a, b, r, f, lat);
        start = 1'b1; op = o; A = a; B = b;
        n = cyc + 1;
        e.r = r;
        e.f = f;
        e.cyc = 32'(n + lat - 1);
        sb.push_back(e);
        blo = n;
        bhi = n + lat - 2;
        last_done = n + lat - 1;
        last_n = n;
    endtask

    task automatic finish_op(input bit noise);
        while (cyc < last_done) begin
            if (noise) begin
                start = 1'($urandom);
                op = 1'($urandom);
                A = 16'($urandom);
                B = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            step;
        end
        start = 1'b0;
    endtask

    task automatic run(input logic o, input logic [15:0] a,
                       input logic [7:0] b, input bit noise);
        issue(o, a, b);
        step;
        finish_op(noise);
    endtask

    // Monitor: busy window, done timing/values, output hold
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(cyc >= blo && cyc <= bhi));
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_done cyc=%0d actual=1 required=0", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", 32'(R), 32'(e.r));
                    chk("flags", 32'(flags), 32'(e.f));
                    chk("done_cycle", 32'(cyc), e.cyc);
                    hold_r = e.r;
                    hold_f = e.f;
                end
            end else begin
                chk("r_hold", 32'(R), 32'(hold_r));
                chk("flags_hold", 32'(flags), 32'(hold_f));
                if (sb.size() != 0 && cyc > int'(sb[0].cyc)) begin
                    chk("missing_done", 32'(cyc), sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
            if (reset) begin
                hold_r = '0;
                hold_f = '0;
            end
        end
    end

    initial begin
        logic [7:0]  b;
        logic [15:0] a;
        logic        o;
        bit          alt;

        repeat (3) step;
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        mon_en = 1'b1;
        step;

        run(1'b0, 16'h0012, 8'h34, 1'b0);
        run(1'b1, 16'h1234, 8'h56, 1'b0);
        run(1'b1, 16'h1234, 8'h00, 1'b0);
        run(1'b1, 16'h1234, 8'h12, 1'b0);
        run(1'b1, 16'h0012, 8'h13, 1'b0);
        run(1'b0, 16'hAB00, 8'h00, 1'b0);
        run(1'b0, 16'h0001, 8'h01, 1'b0);
        step;

        // Abort a MUL mid-CALC with a one-cycle reset
        issue(1'b0, 16'h00AB, 8'hCD);
        step;
        start = 1'b0;
        while (cyc < last_n + 3) step;
        reset = 1'b1;
        bhi = cyc;
        sb.delete();
        last_done = cyc + 1;
        step;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_r", 32'(R), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        run(1'b0, 16'h00FF, 8'hFF, 1'b0);

        // start held high: alternating iterative MUL/DIV back to back
        alt = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (cyc >= last_done) begin
                b = 8'($urandom) | 8'h80;
                a[15:8] = alt ? 8'($urandom_range(0, int'(b) - 1))
                              : 8'($urandom);
                a[7:0] = 8'($urandom);
                issue(alt, a, b);
                alt = ~alt;
            end else begin
                op = 1'($urandom);
                A = 16'($urandom);
                B = 8'($urandom);
            end
            step;
        end
        finish_op(1'b1);

        // Randomised mix including fast paths and CALC-time start noise
        for (int k = 0; k < 60; k++) begin
            o = 1'($urandom);
            case ($urandom_range(0, 5))
                0: b = 8'd0;
                1: b = 8'($urandom_range(1, 7));
                default: b = 8'($urandom);
            endcase
            a = 16'($urandom);
            if (o && b != 8'd0 && $urandom_range(0, 2) != 0)
                a[15:8] = 8'($urandom_range(0, int'(b) - 1));
            run(o, a, b, 1'b1);
            repeat ($urandom_range(0, 2)) step;
        end

        start = 1'b0;
        repeat (3) step;
        chk("drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
